// File: rtl/full_adder.sv
// full_adder: parameterised ripple-carry adder computing a + b + cin.
//
// The combinational outputs (sum, cout, ovf) come straight from the bit-cell
// chain. They do not depend on clk, reset or in_valid.
//
// The registered copies (sum_q, cout_q, ovf_q) capture the combinational
// result on a rising edge when in_valid is high. Otherwise they hold.
// valid_q tracks in_valid one cycle late.
//
// Ports
//   clk       in   1      rising-edge clock for the registered path
//   reset     in   1      async active-high reset, clears the registered path only
//   a, b      in   WIDTH  operands (unsigned; two's complement view for ovf)
//   cin       in   1      carry in
//   in_valid  in   1      qualifies a/b/cin for capture
//   sum       out  WIDTH  (a+b+cin)[WIDTH-1:0]
//   cout      out  1      (a+b+cin)[WIDTH]
//   ovf       out  1      signed overflow: carry into MSB ^ cout
//   sum_q     out  WIDTH  registered sum
//   cout_q    out  1      registered cout
//   ovf_q     out  1      registered ovf
//   valid_q   out  1      registered in_valid
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             valid_q
);

  // c[i] is the carry into bit cell i; c[WIDTH] is the carry out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign sum  = s;
  assign cout = c[WIDTH];
  // Signed overflow occurs when the carry into the sign bit differs from the carry out.
  assign ovf  = c[WIDTH-1] ^ c[WIDTH];

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             valid_d;

  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = s;
      cout_d = c[WIDTH];
      ovf_d  = c[WIDTH-1] ^ c[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // WIDTH=1 instance
  logic a1, b1, cin1, iv1;
  logic s1, co1, ov1, sq1, coq1, ovq1, vq1;
  // WIDTH=4 instance
  logic [3:0] a4, b4, s4, sq4;
  logic cin4, iv4, co4, ov4, coq4, ovq4, vq4;
  // WIDTH=8 instance
  logic [7:0] a8, b8, s8, sq8;
  logic cin8, iv8, co8, ov8, coq8, ovq8, vq8;

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
    .sum(s1), .cout(co1), .ovf(ov1),
    .sum_q(sq1), .cout_q(coq1), .ovf_q(ovq1), .valid_q(vq1)
  );

  full_adder #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .a(a4), .b(b4), .cin(cin4), .in_valid(iv4),
    .sum(s4), .cout(co4), .ovf(ov4),
    .sum_q(sq4), .cout_q(coq4), .ovf_q(ovq4), .valid_q(vq4)
  );

  full_adder #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
    .sum(s8), .cout(co8), .ovf(ov8),
    .sum_q(sq8), .cout_q(coq8), .ovf_q(ovq8), .valid_q(vq8)
  );

  // Scoreboards: expected values pushed at stimulus time, popped when the DUT output is due.
  logic [2:0]  q1c[$];   // {ovf, cout, sum}
  logic [3:0]  q1r[$];   // {valid_q, ovf_q, cout_q, sum_q}
  logic [5:0]  q4c[$];   // {sum[3:0], cout, ovf}
  logic [9:0]  q8c[$];   // {ovf, cout, sum[7:0]}
  logic [10:0] q8r[$];   // {valid_q, ovf_q, cout_q, sum_q[7:0]}

  // Reference model for the 1-bit cell, including signed overflow on a 1-bit range of [-1,0].
  function automatic logic [2:0] model1(input logic a, input logic b, input logic c);
    logic [1:0] u;
    int sr;
    u  = 2'(a) + 2'(b) + 2'(c);
    sr = -int'(a) - int'(b) + int'(c);
    return {((sr < -1) || (sr > 0)), u[1], u[0]};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; iv1 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0; iv4 = 1'b0;
    a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0; iv8 = 1'b0;
    #1;
    checks++;
    if ({vq1, ovq1, coq1, sq1} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_w1 got=%b exp=0000", {vq1, ovq1, coq1, sq1});
    end
    checks++;
    if ({vq8, ovq8, coq8, sq8} !== 11'h0) begin
      failures++;
      $display("FAIL reset_w8 got=%h exp=000", {vq8, ovq8, coq8, sq8});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_exhaustive_w1();
    logic [2:0] exp, got;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a1, b1, cin1} = v;
      q1c.push_back(model1(v[2], v[1], v[0]));
      #1;
      exp = q1c.pop_front();
      got = {ov1, co1, s1};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL exhaustive_w1 i=%0d got{ovf,cout,sum}=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_w4_cases();
    logic [14:0] v4 [5];   // {a, b, cin, sum, cout, ovf}
    logic [14:0] v;
    logic [5:0]  exp;
    v4[0] = {4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
    v4[1] = {4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
    v4[2] = {4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
    v4[3] = {4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    v4[4] = {4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      v = v4[k];
      a4   = v[14:11];
      b4   = v[10:7];
      cin4 = v[6];
      q4c.push_back(v[5:0]);
      #1;
      exp = q4c.pop_front();
      checks++;
      if ({s4, co4, ov4} !== exp) begin
        failures++;
        $display("FAIL w4_case%0d got{sum,cout,ovf}=%b exp=%b", k, {s4, co4, ov4}, exp);
      end
    end
  endtask

  task automatic test_registered();
    logic [3:0] exp;
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; iv1 = 1'b1;
    q1r.push_back({1'b1, 1'b1, 1'b1, 1'b0});
    @(posedge clk); #1;
    exp = q1r.pop_front();
    checks++;
    if ({vq1, ovq1, coq1, sq1} !== exp) begin
      failures++;
      $display("FAIL reg_capture got{v,ovf,cout,sum}=%b exp=%b", {vq1, ovq1, coq1, sq1}, exp);
    end
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1; iv1 = 1'b0;
    q1r.push_back({1'b0, 1'b1, 1'b1, 1'b0});
    @(posedge clk); #1;
    exp = q1r.pop_front();
    checks++;
    if ({vq1, ovq1, coq1, sq1} !== exp) begin
      failures++;
      $display("FAIL reg_hold got{v,ovf,cout,sum}=%b exp=%b", {vq1, ovq1, coq1, sq1}, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    logic [2:0] expc;
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; iv1 = 1'b1;
    q1r.push_back({1'b1, 1'b0, 1'b1, 1'b1});
    @(posedge clk); #1;
    exp = q1r.pop_front();
    checks++;
    if ({vq1, ovq1, coq1, sq1} !== exp) begin
      failures++;
      $display("FAIL mid_capture got=%b exp=%b", {vq1, ovq1, coq1, sq1}, exp);
    end
    #2;
    reset = 1'b1;
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    q1c.push_back(model1(1'b1, 1'b0, 1'b0));
    #1;
    checks++;
    if ({vq1, ovq1, coq1, sq1} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset_clear got=%b exp=0000", {vq1, ovq1, coq1, sq1});
    end
    expc = q1c.pop_front();
    checks++;
    if ({ov1, co1, s1} !== expc) begin
      failures++;
      $display("FAIL comb_during_reset got=%b exp=%b", {ov1, co1, s1}, expc);
    end
    @(posedge clk); #1;
    checks++;
    if ({vq1, ovq1, coq1, sq1} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_over_edge got=%b exp=0000", {vq1, ovq1, coq1, sq1});
    end
    @(negedge clk);
    reset = 1'b0;
    a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0; iv1 = 1'b1;
    q1r.push_back({1'b1, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;
    exp = q1r.pop_front();
    checks++;
    if ({vq1, ovq1, coq1, sq1} !== exp) begin
      failures++;
      $display("FAIL first_after_release got=%b exp=%b", {vq1, ovq1, coq1, sq1}, exp);
    end
    iv1 = 1'b0;
  endtask

  // Random operands with random in_valid, so back-to-back captures and holds are both exercised.
  task automatic test_random_w8();
    logic [7:0] m_sum = 8'h0;
    logic m_cout = 1'b0, m_ovf = 1'b0;
    logic [9:0]  expc;
    logic [10:0] expr;
    int comb_fail = 0, reg_fail = 0;
    for (int n = 0; n < 1000; n++) begin
      logic [8:0] u;
      int sr;
      logic o;
      @(negedge clk);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      iv8  = ($urandom_range(0, 3) != 0);
      u  = 9'(a8) + 9'(b8) + 9'(cin8);
      sr = int'($signed(a8)) + int'($signed(b8)) + int'(cin8);
      o  = (sr > 127) || (sr < -128);
      q8c.push_back({o, u});
      if (iv8) begin
        m_sum  = u[7:0];
        m_cout = u[8];
        m_ovf  = o;
      end
      q8r.push_back({iv8, m_ovf, m_cout, m_sum});
      #1;
      expc = q8c.pop_front();
      checks++;
      if ({ov8, co8, s8} !== expc) begin
        failures++;
        if (comb_fail < 5)
          $display("FAIL rand_comb n=%0d a=%h b=%h cin=%b got=%h exp=%h",
                   n, a8, b8, cin8, {ov8, co8, s8}, expc);
        comb_fail++;
      end
      @(posedge clk); #1;
      expr = q8r.pop_front();
      checks++;
      if ({vq8, ovq8, coq8, sq8} !== expr) begin
        failures++;
        if (reg_fail < 5)
          $display("FAIL rand_reg n=%0d got=%h exp=%h", n, {vq8, ovq8, coq8, sq8}, expr);
        reg_fail++;
      end
    end
    iv8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_exhaustive_w1();
    test_w4_cases();
    test_registered();
    test_reset_mid();
    test_random_w8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
